or_frame_reducer: RTL and testbench



---
 rtl/or_frame_reducer_pkg.sv | 13 +
 rtl/or_frame_reducer_if.sv | 30 +++
 rtl/or_frame_reducer_or_vec.sv | 14 +
 rtl/or_frame_reducer.sv | 99 +++++++++
 tb/tb_or_frame_reducer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/or_frame_reducer_pkg.sv
// Shared types and default sizes for the OR frame reducer.
package or_frame_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

endpackage

// File: rtl/or_frame_reducer_if.sv
// Upstream word stream and downstream result handshake for or_frame_reducer.
interface or_frame_reducer_if
  import or_frame_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_any;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_any, out_count, out_sat
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_any, out_count, out_sat
  );

endinterface

// File: rtl/or_frame_reducer_or_vec.sv
// Bitwise OR built from one 2:1 mux per bit: a bit selects constant 1, else passes b.
module or_vec_using_mux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    assign y[i] = a[i] ? 1'b1 : b[i];
  end

endmodule

// File: rtl/or_frame_reducer.sv
// Reduces each framed run of words to their bitwise OR, with a saturating word count.
module or_frame_reducer
  import or_frame_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst_n,
  or_frame_reducer_if.slave bus
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] or_word;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             in_fire;
  logic             first_word;
  logic             any_chain;

  or_vec_using_mux #(.WIDTH(WIDTH)) u_or (
    .a (acc),
    .b (bus.in_data),
    .y (or_word)
  );

  assign in_fire    = bus.in_valid && bus.in_ready;
  // A word is a frame's first whenever no frame is open; in HOLD it can only fire with out_ready.
  assign first_word = in_fire && (state != ACCUM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (bus.in_valid) begin
          state_next = bus.in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            state_next = bus.in_last ? HOLD : ACCUM;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state != HOLD) || bus.out_ready;
    bus.out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (first_word) begin
      acc <= bus.in_data;
      cnt <= CNT_W'(1);
      sat <= 1'b0;
    end else if (in_fire) begin
      acc <= or_word;
      if (cnt == '1) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Reduction done as a mux chain to keep the datapath free of OR operators.
  always_comb begin
    any_chain = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      any_chain = acc[i] ? 1'b1 : any_chain;
    end
  end

  assign bus.out_data  = acc;
  assign bus.out_count = cnt;
  assign bus.out_sat   = sat;
  assign bus.out_any   = any_chain;

endmodule

// File: tb/tb_or_frame_reducer.sv
// Directed vector table plus randomized traffic against a frame-level reference model.
module tb_or_frame_reducer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned MAXC  = (1 << CNT_W) - 1;

  typedef struct {
    logic       rst_n;
    logic       iv;
    logic [7:0] d;
    logic       il;
    logic       ordy;
    logic       chk_ir;
    logic       ir;
    logic       chk_data;
    logic       ov;
    logic [7:0] od;
    logic [3:0] cnt;
    logic       sat;
    logic       any;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  or_frame_reducer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bif ();

  or_frame_reducer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ir < 0 means in_ready is not checked for this row.
  function automatic vec_t row(logic r, logic iv, logic [7:0] d, logic il, logic ordy,
                               int ir, logic ov, logic [7:0] od, logic [3:0] c, logic s);
    vec_t v;
    v.rst_n    = r;
    v.iv       = iv;
    v.d        = d;
    v.il       = il;
    v.ordy     = ordy;
    v.chk_ir   = (ir >= 0);
    v.ir       = (ir > 0);
    v.chk_data = ov || !r;
    v.ov       = ov;
    v.od       = od;
    v.cnt      = c;
    v.sat      = s;
    v.any      = (od != 8'h00);
    return v;
  endfunction

  task automatic drive(input logic r, input logic iv, input logic [7:0] d,
                       input logic il, input logic ordy);
    rst_n         = r;
    bif.in_valid  = iv;
    bif.in_data   = d;
    bif.in_last   = il;
    bif.out_ready = ordy;
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    drive(v.rst_n, v.iv, v.d, v.il, v.ordy);
    #1;
    if (v.chk_ir) chk("in_ready", 32'(bif.in_ready), 32'(v.ir));
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bif.out_valid), 32'(v.ov));
    if (v.chk_data) begin
      chk("out_data", 32'(bif.out_data), 32'(v.od));
      chk("out_count", 32'(bif.out_count), 32'(v.cnt));
      chk("out_sat", 32'(bif.out_sat), 32'(v.sat));
      chk("out_any", 32'(bif.out_any), 32'(v.any));
    end
  endtask

  initial begin
    logic       held, open, done, out_fire, fire, exp_ir;
    logic [7:0] m_acc, h_d;
    int         m_n, h_n;
    logic       h_sat;
    logic       iv, il, ordy;
    logic [7:0] d;
    int         last_div;

    drive(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);

    // reset held with in_valid asserted
    vecs.push_back(row(0, 1, 8'hAA, 0, 0, -1, 0, 8'h00, 0, 0));
    vecs.push_back(row(0, 1, 8'hAA, 0, 0,  1, 0, 8'h00, 0, 0));
    vecs.push_back(row(1, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0));
    // three-word frame with an idle gap inside it
    vecs.push_back(row(1, 1, 8'h01, 0, 1,  1, 0, 8'h00, 0, 0));
    vecs.push_back(row(1, 1, 8'h10, 0, 1,  1, 0, 8'h00, 0, 0));
    vecs.push_back(row(1, 0, 8'hFF, 1, 1,  1, 0, 8'h00, 0, 0));
    vecs.push_back(row(1, 1, 8'h80, 1, 1,  1, 1, 8'h91, 3, 0));
    vecs.push_back(row(1, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0));
    // backpressure, then back-to-back frame on release
    vecs.push_back(row(1, 1, 8'h0F, 1, 0,  1, 1, 8'h0F, 1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(row(1, 1, 8'h55, 1, 0, 0, 1, 8'h0F, 1, 0));
    vecs.push_back(row(1, 1, 8'hF0, 1, 1,  1, 1, 8'hF0, 1, 0));
    vecs.push_back(row(1, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0));
    // 17-word frame saturates the count; next frame clears the flag
    for (int i = 0; i < 16; i++)
      vecs.push_back(row(1, 1, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0));
    vecs.push_back(row(1, 1, 8'h02, 1, 1,  1, 1, 8'h02, 4'(MAXC), 1));
    vecs.push_back(row(1, 1, 8'h03, 1, 1,  1, 1, 8'h03, 1, 0));
    vecs.push_back(row(1, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0));
    // all-zero single-word frame
    vecs.push_back(row(1, 1, 8'h00, 1, 1,  1, 1, 8'h00, 1, 0));
    vecs.push_back(row(1, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0));
    // reset in the middle of a frame
    vecs.push_back(row(1, 1, 8'h30, 0, 1,  1, 0, 8'h00, 0, 0));
    vecs.push_back(row(1, 1, 8'h41, 0, 1,  1, 0, 8'h00, 0, 0));
    vecs.push_back(row(0, 0, 8'h00, 0, 1, -1, 0, 8'h00, 0, 0));
    vecs.push_back(row(1, 1, 8'h04, 1, 1,  1, 1, 8'h04, 1, 0));
    vecs.push_back(row(1, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0));

    foreach (vecs[i]) apply_vec(vecs[i]);

    // randomized traffic; block is idle here
    held  = 1'b0;
    open  = 1'b0;
    m_acc = '0;
    m_n   = 0;
    h_d   = '0;
    h_n   = 0;
    h_sat = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      last_div = ((cyc / 500) % 2 == 1) ? 25 : 3;
      iv   = ($urandom_range(0, 9) < 7);
      il   = ($urandom_range(0, last_div - 1) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      d    = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      @(negedge clk);
      drive(1'b1, iv, d, il, ordy);
      #1;
      exp_ir = !held || ordy;
      chk("rnd_in_ready", 32'(bif.in_ready), 32'(exp_ir));

      out_fire = held && ordy;
      fire     = iv && exp_ir;
      done     = 1'b0;
      if (fire) begin
        if (!open) begin
          m_acc = d;
          m_n   = 1;
          open  = 1'b1;
        end else begin
          m_acc = m_acc | d;
          m_n++;
        end
        if (il) begin
          done = 1'b1;
          open = 1'b0;
        end
      end
      if (out_fire) held = 1'b0;
      if (done) begin
        held  = 1'b1;
        h_d   = m_acc;
        h_n   = (m_n > int'(MAXC)) ? int'(MAXC) : m_n;
        h_sat = (m_n > int'(MAXC));
      end

      @(posedge clk);
      #1;
      chk("rnd_out_valid", 32'(bif.out_valid), 32'(held));
      if (held) begin
        chk("rnd_out_data", 32'(bif.out_data), 32'(h_d));
        chk("rnd_out_count", 32'(bif.out_count), 32'(h_n));
        chk("rnd_out_sat", 32'(bif.out_sat), 32'(h_sat));
        chk("rnd_out_any", 32'(bif.out_any), 32'(h_d != 8'h00));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
